// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: op encodings, FSM states
// and the datapath width.
package alu_pkg;

   localparam int ALU_W = 16;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu16.sv
// 16-bit ALU: ADD, SUB (a + ~b + 1, cout = no borrow), AND, OR.
// cout is bit 16 of the extended result; zero for the logic ops.
module alu16
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [1:0]       sel,
   output logic [ALU_W-1:0] res,
   output logic             cout
);

   logic [ALU_W:0] w_ext;

   // Op decode on a 17-bit extended result
   always_comb begin
      w_ext = '0;
      case (sel)
         ALU_ADD: w_ext = {1'b0, a} + {1'b0, b};
         ALU_SUB: w_ext = {1'b0, a} + {1'b0, ~b} + 17'd1;
         ALU_AND: w_ext = {1'b0, a & b};
         default: w_ext = {1'b0, a | b};
      endcase
   end

   assign res  = w_ext[ALU_W-1:0];
   assign cout = w_ext[ALU_W];

endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin selector: first set valid at or after ptr,
// wrapping from NREQ-1 to 0. Returns a one-hot grant and its index.
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   // Rotating search from the pointer
   always_comb begin
      int          j;
      logic [IW-1:0] w_j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      w_j   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j   = (int'(ptr) + k) % NREQ;
         w_j = IW'(j);
         if (!any && valid[w_j]) begin
            any        = 1'b1;
            grant[w_j] = 1'b1;
            idx        = w_j;
         end
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one alu16 among NREQ requesters with round-robin arbitration.
// Sequence per op: IDLE (grant) -> EXEC (ALU from registered operands)
// -> RESP (hold response until rsp_ready).
// Optional ALU_ARB_STATS_EN adds saturating stat_ops / stat_stall counters.
//
// state   | meaning
// IDLE    | waiting for req_valid; winner latched on grant
// EXEC    | ALU driven from latched operands; result captured
// RESP    | rsp_valid held until rsp_ready
module alu_share_arb
   import alu_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [ALU_W*NREQ-1:0] req_a,
   input  logic [ALU_W*NREQ-1:0] req_b,
   input  logic [2*NREQ-1:0]     req_sel,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IW-1:0]         rsp_id,
   output logic [ALU_W-1:0]      rsp_res,
   output logic                  rsp_cout,
   output logic                  busy
`ifdef ALU_ARB_STATS_EN
  ,output logic [15:0]           stat_ops,
   output logic [15:0]           stat_stall
`endif
);

   state_t           r_state;
   state_t           w_next;
   logic [IW-1:0]    r_ptr;
   logic [ALU_W-1:0] r_a;
   logic [ALU_W-1:0] r_b;
   logic [1:0]       r_sel;
   logic [IW-1:0]    r_id;
   logic [IW-1:0]    r_rsp_id;
   logic [ALU_W-1:0] r_rsp_res;
   logic             r_rsp_cout;
   logic [NREQ-1:0]  w_grant;
   logic [IW-1:0]    w_idx;
   logic             w_any;
   logic [ALU_W-1:0] w_alu_res;
   logic             w_alu_cout;
   logic             w_take;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid (req_valid),
      .ptr   (r_ptr),
      .grant (w_grant),
      .idx   (w_idx),
      .any   (w_any)
   );

   alu16 u_alu (
      .a    (r_a),
      .b    (r_b),
      .sel  (r_sel),
      .res  (w_alu_res),
      .cout (w_alu_cout)
   );

   assign w_take = (r_state == ST_IDLE) && w_any;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_any)     w_next = ST_EXEC;
         ST_EXEC:                w_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_next = ST_IDLE;
         default:                w_next = ST_IDLE;
      endcase
   end

   // FSM outputs; grant is only visible while idle
   always_comb begin
      req_ready = (r_state == ST_IDLE) ? w_grant : '0;
      rsp_valid = (r_state == ST_RESP);
      busy      = (r_state != ST_IDLE);
   end

   // Operand latch, pointer advance and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_sel      <= '0;
         r_id       <= '0;
         r_rsp_id   <= '0;
         r_rsp_res  <= '0;
         r_rsp_cout <= 1'b0;
      end else begin
         if (w_take) begin
            r_a   <= req_a[ALU_W*int'(w_idx) +: ALU_W];
            r_b   <= req_b[ALU_W*int'(w_idx) +: ALU_W];
            r_sel <= req_sel[2*int'(w_idx) +: 2];
            r_id  <= w_idx;
            r_ptr <= (w_idx == IW'(NREQ-1)) ? '0 : w_idx + IW'(1);
         end
         if (r_state == ST_EXEC) begin
            r_rsp_id   <= r_id;
            r_rsp_res  <= w_alu_res;
            r_rsp_cout <= w_alu_cout;
         end
      end
   end

   assign rsp_id   = r_rsp_id;
   assign rsp_res  = r_rsp_res;
   assign rsp_cout = r_rsp_cout;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] r_stat_ops;
   logic [15:0] r_stat_stall;

   // Saturating response and stall counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_ops   <= '0;
         r_stat_stall <= '0;
      end else if (r_state == ST_RESP) begin
         if (rsp_ready) begin
            if (r_stat_ops != 16'hffff) r_stat_ops <= r_stat_ops + 16'd1;
         end else begin
            if (r_stat_stall != 16'hffff) r_stat_stall <= r_stat_stall + 16'd1;
         end
      end
   end

   assign stat_ops   = r_stat_ops;
   assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized and directed bench for alu_share_arb against a
// transaction-level model (round-robin order, 2-cycle latency, held response).
module tb_alu_share_arb;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [16*N-1:0] req_a;
   logic [16*N-1:0] req_b;
   logic [2*N-1:0]  req_sel;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [15:0]     rsp_res;
   logic            rsp_cout;
   logic            busy;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]     stat_ops;
   logic [15:0]     stat_stall;
`endif

   always #5 clk = ~clk;

   alu_share_arb #(.NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_res   (rsp_res),
      .rsp_cout  (rsp_cout),
      .busy      (busy)
`ifdef ALU_ARB_STATS_EN
     ,.stat_ops  (stat_ops),
      .stat_stall(stat_stall)
`endif
   );

   int errs   = 0;
   int checks = 0;

   // pending requests per requester
   bit          pv [N];
   logic [15:0] pa [N];
   logic [15:0] pb [N];
   logic [1:0]  ps [N];

   // model state
   int          cyc = 0;
   int          m_ptr;
   bit          m_out;
   int          gcyc;
   int          m_id;
   logic [15:0] m_res;
   bit          m_cout;
   int          last_id;
   logic [15:0] last_res;
   bit          last_cout;
   int          m_ops;
   int          m_stall;
   int          resp_cnt;
   int          rdy_low_left = 0;
   bit          hold_all = 0;
   bit          rnd_on = 0;
   int          glog_id[$];
   int          glog_cyc[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void ref_alu(input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] s,
                                   output logic [15:0] r, output bit c);
      int sum;
      case (s)
         2'd0: begin sum = int'(a) + int'(b); r = sum[15:0]; c = (sum > 65535); end
         2'd1: begin r = a - b; c = (a >= b); end
         2'd2: begin r = a & b; c = 1'b0; end
         default: begin r = a | b; c = 1'b0; end
      endcase
   endfunction

   task automatic fill(input int i);
      pv[i] = 1'b1;
      pa[i] = 16'($urandom);
      pb[i] = 16'($urandom);
      ps[i] = 2'($urandom_range(0, 3));
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = pv[i];
         req_a[16*i +: 16]   = pa[i];
         req_b[16*i +: 16]   = pb[i];
         req_sel[2*i +: 2]   = ps[i];
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_ptr = 0; last_id = 0; last_res = '0; last_cout = 0;
      m_ops = 0; m_stall = 0; resp_cnt = 0;
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cyc++;
         rst_n = 1'b0;
         for (int i = 0; i < N; i++) pv[i] = 1'b0;
         drive();
         rsp_ready = 1'b1;
      end
      model_reset();
   endtask

   task automatic step();
      int win;
      logic [31:0] exp_rdy;
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (hold_all) begin
            if (!pv[i]) fill(i);
         end else if (rnd_on) begin
            if (!pv[i]) begin
               if ($urandom_range(0, 2) == 0) fill(i);
            end else if ($urandom_range(0, 31) == 0) begin
               pv[i] = 1'b0;
            end
         end
      end
      if (m_out && cyc >= gcyc + 2 && rdy_low_left > 0) begin
         rsp_ready = 1'b0;
         rdy_low_left--;
      end else if (rnd_on) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
         rsp_ready = 1'b1;
      end
      drive();
      #1;
`ifdef ALU_ARB_STATS_EN
      chk("stat_ops", stat_ops, m_ops);
      chk("stat_stall", stat_stall, m_stall);
`endif
      if (m_out) begin
         chk("busy_op", busy, 1);
         chk("ready_while_busy", req_ready, 0);
         if (cyc >= gcyc + 2) begin
            chk("rsp_valid_resp", rsp_valid, 1);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_res", rsp_res, m_res);
            chk("rsp_cout", rsp_cout, m_cout);
            resp_cnt++;
            if (!rsp_ready) begin
               if (m_stall < 65535) m_stall++;
            end else begin
               m_out = 0;
               last_id = m_id; last_res = m_res; last_cout = m_cout;
               if (m_ops < 65535) m_ops++;
            end
         end else begin
            chk("rsp_valid_exec", rsp_valid, 0);
            chk("hold_id", rsp_id, last_id);
            chk("hold_res", rsp_res, last_res);
            chk("hold_cout", rsp_cout, last_cout);
         end
      end else begin
         chk("busy_idle", busy, 0);
         chk("rsp_valid_idle", rsp_valid, 0);
         chk("hold_id", rsp_id, last_id);
         chk("hold_res", rsp_res, last_res);
         chk("hold_cout", rsp_cout, last_cout);
         win = -1;
         for (int k = 0; k < N; k++)
            if (win < 0 && pv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         exp_rdy = (win < 0) ? 32'd0 : (32'd1 << win);
         chk("req_ready", req_ready, exp_rdy);
         if (win >= 0) begin
            m_out = 1; gcyc = cyc; m_id = win; resp_cnt = 0;
            ref_alu(pa[win], pb[win], ps[win], m_res, m_cout);
            m_ptr = (win + 1) % N;
            pv[win] = 1'b0;
            glog_id.push_back(win);
            glog_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (m_out && k < max) begin step(); k++; end
      chk("timeout_idle", m_out, 0);
   endtask

   task automatic send(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] s, input logic [15:0] er, input bit ec,
                       input string tag);
      int k = 0;
      wait_idle(50);
      pv[id] = 1'b1; pa[id] = a; pb[id] = b; ps[id] = s;
      while (!m_out && k < 20) begin step(); k++; end
      chk({tag, "_granted"}, m_out, 1);
      wait_idle(50);
      chk({tag, "_res"}, last_res, er);
      chk({tag, "_cout"}, last_cout, ec);
      chk({tag, "_id"}, last_id, id);
   endtask

   initial begin
      int any_left;
      int k;
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin pv[i] = 0; pa[i] = '0; pb[i] = '0; ps[i] = '0; end
      drive();
      do_reset(3);
      repeat (3) step();

      send(0, 16'hff00, 16'h00ab, 2'b00, 16'hffab, 1'b0, "req0_add");
      send(2, 16'hffa0, 16'h00ff, 2'b00, 16'h009f, 1'b1, "req2_add");
      send(2, 16'hffa0, 16'h00ff, 2'b10, 16'h00a0, 1'b0, "req2_and");
      send(2, 16'hffa0, 16'h00ff, 2'b11, 16'hffff, 1'b0, "req2_or");
      send(1, 16'h0005, 16'h0007, 2'b01, 16'hfffe, 1'b0, "req1_sub");
      send(3, 16'h0007, 16'h0005, 2'b01, 16'h0002, 1'b1, "req3_sub");

      // all four requesters continuously valid
      do_reset(1);
      glog_id.delete(); glog_cyc.delete();
      hold_all = 1;
      repeat (16) step();
      hold_all = 0;
      wait_idle(50);
      chk("order_len", (glog_id.size() >= 5), 1);
      if (glog_id.size() >= 5) begin
         chk("order0", glog_id[0], 0);
         chk("order1", glog_id[1], 1);
         chk("order2", glog_id[2], 2);
         chk("order3", glog_id[3], 3);
         chk("order4", glog_id[4], 0);
         for (int i = 1; i < 5; i++) chk("grant_spacing", glog_cyc[i] - glog_cyc[i-1], 3);
      end

      // response backpressure for five RESP cycles
      do_reset(1);
      step();
      rdy_low_left = 5;
      send(1, 16'h1234, 16'h4321, 2'b11, 16'h5335, 1'b0, "stall_or");
      chk("stall_resp_cycles", resp_cnt, 6);
      step();
`ifdef ALU_ARB_STATS_EN
      chk("stall_stat_stall", stat_stall, 5);
      chk("stall_stat_ops", stat_ops, 1);
`endif

      // reset while in EXEC, with the pointer moved away from 0
      do_reset(1);
      pv[2] = 1'b1; pa[2] = 16'h0101; pb[2] = 16'h0202; ps[2] = 2'b00;
      step();
      chk("pre_rst_grant", m_out, 1);
      do_reset(1);
      pv[1] = 1'b1; pa[1] = 16'h00f0; pb[1] = 16'h000f; ps[1] = 2'b11;
      pv[3] = 1'b1; pa[3] = 16'h0003; pb[3] = 16'h0004; ps[3] = 2'b00;
      glog_id.delete(); glog_cyc.delete();
      step();
      chk("post_rst_grant_cnt", glog_id.size(), 1);
      if (glog_id.size() == 1) chk("post_rst_winner", glog_id[0], 1);
      wait_idle(50);
      chk("post_rst_res", last_res, 16'h00ff);

      // randomized traffic with random backpressure and request drops
      rnd_on = 1;
      repeat (3000) step();
      rnd_on = 0;
      k = 0;
      any_left = 1;
      while (any_left != 0 && k < 200) begin
         step();
         k++;
         any_left = m_out ? 1 : 0;
         for (int i = 0; i < N; i++) if (pv[i]) any_left = 1;
      end
      chk("drain_timeout", any_left, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
